cu_fsm_wait: RTL and testbench

//  Multicycle control-unit FSM for the RV32 Otter core. It sequences fetch, execute and

---
 rtl/cu_fsm_wait_if.sv | 31 +++
 rtl/cu_fsm_wait.sv | 161 ++++++++++++++++
 tb/tb_cu_fsm_wait.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cu_fsm_wait_if.sv
// Control-unit boundary: instruction/interrupt inputs and datapath enables.
// master = control unit side, slave = datapath/CSR side.
interface cu_fsm_wait_if #(
  parameter int N_IRQ = 4
) ();
  logic [9:0]       IR;
  logic [N_IRQ-1:0] IRQ;
  logic             MIE;
  logic             PC_WRITE;
  logic             REG_WRITE;
  logic             MEM_WE2;
  logic             MEM_RDEN1;
  logic             MEM_RDEN2;
  logic             RESET;
  logic             CSR_WE;
  logic             INT_TAKEN;
  logic [3:0]       INT_ID;
  logic             ILLEGAL;

  modport master (
    input  IR, IRQ, MIE,
    output PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2,
           RESET, CSR_WE, INT_TAKEN, INT_ID, ILLEGAL
  );

  modport slave (
    output IR, IRQ, MIE,
    input  PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2,
           RESET, CSR_WE, INT_TAKEN, INT_ID, ILLEGAL
  );
endinterface

// File: rtl/cu_fsm_wait.sv
// Multicycle Otter control unit: fetch/exec/load-writeback with MEM_LAT-cycle memory
// wait states, MIE-gated priority interrupts and illegal-opcode retirement as NOP.
module cu_fsm_wait #(
  parameter int MEM_LAT = 1,
  parameter int N_IRQ   = 4
) (
  input  logic           CLK,
  input  logic           RST,
  cu_fsm_wait_if.master  bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  // Counter runs from MEM_LAT-2 down to 0, giving MEM_LAT-1 wait cycles.
  localparam logic [CW-1:0] WAIT_INIT = CW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_FETCH      = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_EXEC       = 3'd3,
    S_LOAD_WAIT  = 3'd4,
    S_WTBK       = 3'd5,
    S_INTR       = 3'd6
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    int_id;
  logic [3:0]    irq_first;
  logic          irq_pend;
  logic [6:0]    opcode;
  logic [2:0]    funct3;

  assign opcode   = bus.IR[6:0];
  assign funct3   = bus.IR[9:7];
  assign irq_pend = bus.MIE & (|bus.IRQ);
  assign bus.INT_ID = int_id;

  // Scan from the top so the lowest set line wins.
  always_comb begin
    irq_first = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (bus.IRQ[i]) irq_first = 4'(i);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_INIT;
      cnt    <= '0;
      int_id <= '0;
    end else begin
      case (state)
        S_INIT: state <= S_FETCH;
        S_FETCH: begin
          if (MEM_LAT == 1) begin
            state <= S_EXEC;
          end else begin
            state <= S_FETCH_WAIT;
            cnt   <= WAIT_INIT;
          end
        end
        S_FETCH_WAIT: begin
          if (cnt == '0) state <= S_EXEC;
          else           cnt   <= cnt - CW'(1);
        end
        S_EXEC: begin
          if (opcode == OP_LOAD) begin
            if (MEM_LAT == 1) begin
              state <= S_WTBK;
            end else begin
              state <= S_LOAD_WAIT;
              cnt   <= WAIT_INIT;
            end
          end else if (irq_pend) begin
            state  <= S_INTR;
            int_id <= irq_first;
          end else begin
            state <= S_FETCH;
          end
        end
        S_LOAD_WAIT: begin
          if (cnt == '0) state <= S_WTBK;
          else           cnt   <= cnt - CW'(1);
        end
        S_WTBK: begin
          if (irq_pend) begin
            state  <= S_INTR;
            int_id <= irq_first;
          end else begin
            state <= S_FETCH;
          end
        end
        S_INTR:  state <= S_FETCH;
        default: state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    bus.PC_WRITE  = 1'b0;
    bus.REG_WRITE = 1'b0;
    bus.MEM_WE2   = 1'b0;
    bus.MEM_RDEN1 = 1'b0;
    bus.MEM_RDEN2 = 1'b0;
    bus.RESET     = 1'b0;
    bus.CSR_WE    = 1'b0;
    bus.INT_TAKEN = 1'b0;
    bus.ILLEGAL   = 1'b0;
    case (state)
      S_INIT:  bus.RESET     = 1'b1;
      S_FETCH: bus.MEM_RDEN1 = 1'b1;
      S_EXEC: begin
        bus.PC_WRITE  = 1'b1;
        bus.REG_WRITE = 1'b1;
        case (opcode)
          OP_BRANCH: bus.REG_WRITE = 1'b0;
          OP_STORE: begin
            bus.MEM_WE2   = 1'b1;
            bus.REG_WRITE = 1'b0;
          end
          OP_LOAD: begin
            bus.MEM_RDEN2 = 1'b1;
            bus.PC_WRITE  = 1'b0;
            bus.REG_WRITE = 1'b0;
          end
          OP_SYS: begin
            if (funct3 != 3'b000) bus.CSR_WE    = 1'b1;
            else                  bus.REG_WRITE = 1'b0;
          end
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: ;
          default: begin
            bus.REG_WRITE = 1'b0;
            bus.ILLEGAL   = 1'b1;
          end
        endcase
      end
      S_WTBK: begin
        bus.PC_WRITE  = 1'b1;
        bus.REG_WRITE = 1'b1;
      end
      S_INTR: begin
        bus.INT_TAKEN = 1'b1;
        bus.PC_WRITE  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cu_fsm_wait.sv
// Instruction-level reference: each instruction expands to its expected per-cycle
// enable vectors, compared against the control unit one step after every rising edge.
module tb_cu_fsm_wait;

  localparam int ML = 3;
  localparam int B_PC = 8, B_REG = 7, B_WE2 = 6, B_RD1 = 5, B_RD2 = 4;
  localparam int B_RST = 3, B_CSR = 2, B_INT = 1, B_ILL = 0;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] model_id = 4'd0;

  cu_fsm_wait_if #(.N_IRQ(4)) bus ();

  cu_fsm_wait #(.MEM_LAT(ML), .N_IRQ(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] obs_vec();
    return {bus.PC_WRITE, bus.REG_WRITE, bus.MEM_WE2, bus.MEM_RDEN1, bus.MEM_RDEN2,
            bus.RESET, bus.CSR_WE, bus.INT_TAKEN, bus.ILLEGAL};
  endfunction

  function automatic logic [8:0] bit1(int b);
    logic [8:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // Enables the instruction's execute cycle must show.
  function automatic logic [8:0] exec_exp(logic [9:0] ir);
    logic [8:0] v;
    v = bit1(B_PC) | bit1(B_REG);
    case (ir[6:0])
      7'b1100011: v[B_REG] = 1'b0;
      7'b0100011: begin v[B_WE2] = 1'b1; v[B_REG] = 1'b0; end
      7'b0000011: begin v[B_RD2] = 1'b1; v[B_PC] = 1'b0; v[B_REG] = 1'b0; end
      7'b1110011: begin
        if (ir[9:7] != 3'b000) v[B_CSR] = 1'b1;
        else                   v[B_REG] = 1'b0;
      end
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0110011: ;
      default: begin v[B_REG] = 1'b0; v[B_ILL] = 1'b1; end
    endcase
    return v;
  endfunction

  function automatic logic [3:0] lowest(logic [3:0] irq);
    for (int i = 0; i < 4; i++) if (irq[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Entered anywhere in the cycle before FETCH; returns in the instruction's last cycle.
  task automatic run_instr(input logic [9:0] ir, input logic [3:0] irq, input logic mie);
    logic [8:0] q[$];
    logic [3:0] idq[$];
    int         n;
    q.push_back(bit1(B_RD1));
    repeat (ML - 1) q.push_back(9'd0);
    q.push_back(exec_exp(ir));
    if (ir[6:0] == 7'b0000011) begin
      repeat (ML - 1) q.push_back(9'd0);
      q.push_back(bit1(B_PC) | bit1(B_REG));
    end
    n = q.size();
    for (int k = 0; k < n; k++) idq.push_back(model_id);
    if (mie && irq != 4'd0) begin
      model_id = lowest(irq);
      q.push_back(bit1(B_INT) | bit1(B_PC));
      idq.push_back(model_id);
    end
    for (int k = 0; k < q.size(); k++) begin
      @(posedge CLK);
      #1;
      check($sformatf("outs ir=%h step%0d", ir, k), obs_vec(), q[k]);
      check($sformatf("int_id ir=%h step%0d", ir, k), {5'd0, bus.INT_ID}, {5'd0, idq[k]});
      if (k == 0) begin
        bus.IR  = ir;
        bus.IRQ = irq;
        bus.MIE = mie;
      end
    end
  endtask

  logic [6:0] ops [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b1110011, 7'b0110111, 7'b0010111,
                           7'b1101111, 7'b1100111, 7'b0000000, 7'b1111111};

  initial begin
    logic [9:0] ir;
    logic [3:0] irq;
    bus.IR  = 10'h033;
    bus.IRQ = 4'd0;
    bus.MIE = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset outs", obs_vec(), bit1(B_RST));
    check("reset int_id", {5'd0, bus.INT_ID}, 9'd0);
    RST = 1'b0;
    #1;
    check("init outs", obs_vec(), bit1(B_RST));

    run_instr(10'h033, 4'd0, 1'b0);
    run_instr(10'h003, 4'd0, 1'b0);
    run_instr(10'h033, 4'b0110, 1'b1);
    for (int i = 0; i < 10; i++) run_instr(ops[i], 4'b1111, 1'b0);
    run_instr(10'h000, 4'd0, 1'b0);
    run_instr(10'h0F3, 4'd0, 1'b0);
    run_instr(10'h073, 4'd0, 1'b0);
    run_instr(10'h07F, 4'b1000, 1'b1);
    run_instr(10'h003, 4'b0100, 1'b1);

    // Load, then asynchronous reset in the middle of its wait state.
    @(posedge CLK);
    #1;
    check("pre-rst fetch", obs_vec(), bit1(B_RD1));
    bus.IR  = 10'h003;
    bus.IRQ = 4'd0;
    bus.MIE = 1'b0;
    repeat (ML + 1) @(posedge CLK);
    #2;
    check("load_wait outs", obs_vec(), 9'd0);
    RST = 1'b1;
    #1;
    model_id = 4'd0;
    check("async rst outs", obs_vec(), bit1(B_RST));
    check("async rst int_id", {5'd0, bus.INT_ID}, 9'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("post-rst init", obs_vec(), bit1(B_RST));
    run_instr(10'h033, 4'd0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ir  = {3'($urandom_range(7)), ops[$urandom_range(11)]};
      if ($urandom_range(3) == 0) ir[6:0] = 7'($urandom);
      irq = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
      run_instr(ir, irq, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
